// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: one entry each for ALU and load results, drained oldest-first
// into the register file's single write port. Writes to register 0 are dropped and counted.
module regfile_wb_arbiter #(
  parameter int COUNT     = 32,
  parameter int BUS_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          alu_valid,
  input  logic [$clog2(COUNT)-1:0]      alu_addr,
  input  logic [BUS_WIDTH-1:0]          alu_data,
  output logic                          alu_ready,
  input  logic                          mem_valid,
  input  logic [$clog2(COUNT)-1:0]      mem_addr,
  input  logic [BUS_WIDTH-1:0]          mem_data,
  output logic                          mem_ready,
  output logic                          rf_wr_en,
  output logic [$clog2(COUNT)-1:0]      rf_write_addr,
  output logic [BUS_WIDTH-1:0]          rf_data_in,
  output logic [7:0]                    zero_drop_cnt,
  output logic                          busy
);
  localparam int ADDR_WIDTH = $clog2(COUNT);

  logic                  alu_held, mem_held, mem_first;
  logic [ADDR_WIDTH-1:0] alu_addr_q, mem_addr_q;
  logic [BUS_WIDTH-1:0]  alu_data_q, mem_data_q;
  logic                  active;
  logic                  grant_alu, grant_mem;
  logic                  alu_acc, mem_acc, alu_cap, mem_cap, alu_zero, mem_zero;
  logic                  alu_held_nx, mem_held_nx;
  logic [8:0]            cnt_sum;

  // Outputs are forced idle while in reset or flushing.
  assign active    = rst_n & ~flush;
  assign grant_alu = active & alu_held & (~mem_held | ~mem_first);
  assign grant_mem = active & mem_held & (~alu_held | mem_first);

  assign alu_ready = active & (~alu_held | grant_alu);
  assign mem_ready = active & (~mem_held | grant_mem);

  assign alu_acc  = alu_valid & alu_ready;
  assign mem_acc  = mem_valid & mem_ready;
  assign alu_cap  = alu_acc & (alu_addr != '0);
  assign mem_cap  = mem_acc & (mem_addr != '0);
  assign alu_zero = alu_acc & (alu_addr == '0);
  assign mem_zero = mem_acc & (mem_addr == '0);

  assign alu_held_nx = alu_cap | (alu_held & ~grant_alu);
  assign mem_held_nx = mem_cap | (mem_held & ~grant_mem);

  assign cnt_sum = {1'b0, zero_drop_cnt} + {8'd0, alu_zero} + {8'd0, mem_zero};

  assign rf_wr_en      = grant_alu | grant_mem;
  assign rf_write_addr = grant_mem ? mem_addr_q : (grant_alu ? alu_addr_q : '0);
  assign rf_data_in    = grant_mem ? mem_data_q : (grant_alu ? alu_data_q : '0);
  assign busy          = alu_held | mem_held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_held      <= 1'b0;
      mem_held      <= 1'b0;
      mem_first     <= 1'b0;
      zero_drop_cnt <= 8'd0;
    end else if (flush) begin
      alu_held  <= 1'b0;
      mem_held  <= 1'b0;
      mem_first <= 1'b0;
    end else begin
      alu_held      <= alu_held_nx;
      mem_held      <= mem_held_nx;
      zero_drop_cnt <= (cnt_sum > 9'd255) ? 8'hFF : cnt_sum[7:0];
      // With both held afterwards, the entry not newly captured is the older one;
      // a same-edge tie goes to the load.
      if (alu_held_nx && mem_held_nx)
        mem_first <= ~mem_cap | alu_cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_addr_q <= '0;
      alu_data_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      if (alu_cap) begin
        alu_addr_q <= alu_addr;
        alu_data_q <= alu_data;
      end
      if (mem_cap) begin
        mem_addr_q <= mem_addr;
        mem_data_q <= mem_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: timestamp-based age model predicts every cycle's outputs.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu_addr = '0, mem_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, rf_wr_en, busy;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_data_in;
  logic [7:0]  zero_drop_cnt;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.COUNT(32), .BUS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_wr_en(rf_wr_en), .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in),
    .zero_drop_cnt(zero_drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [48:0] act;
  assign act = {rf_wr_en, rf_write_addr, rf_data_in, alu_ready, mem_ready, busy, zero_drop_cnt};

  // Reference model: each entry remembers the cycle it was captured; oldest wins, tie -> load.
  int          cyc = 0;
  bit          a_h, m_h;
  logic [4:0]  a_ad, m_ad;
  logic [31:0] a_d, m_d;
  int          a_t, m_t, cnt;
  bit          ga, gm, e_ar, e_mr;
  logic [48:0] exp_v;

  function automatic void model_reset();
    a_h = 0; m_h = 0; cnt = 0;
  endfunction

  function automatic void predict();
    logic [4:0]  wa;
    logic [31:0] wd;
    ga = 0; gm = 0;
    if (!flush) begin
      if (a_h && m_h) begin
        if (m_t <= a_t) gm = 1; else ga = 1;
      end else if (a_h) ga = 1;
      else if (m_h) gm = 1;
    end
    wa = gm ? m_ad : (ga ? a_ad : 5'd0);
    wd = gm ? m_d : (ga ? a_d : 32'd0);
    e_ar = !flush && (!a_h || ga);
    e_mr = !flush && (!m_h || gm);
    exp_v = {(ga | gm), wa, wd, e_ar, e_mr, (a_h | m_h), 8'(cnt)};
  endfunction

  function automatic void model_update();
    if (flush) begin
      a_h = 0; m_h = 0;
    end else begin
      if (ga) a_h = 0;
      if (gm) m_h = 0;
      if (alu_valid && e_ar) begin
        if (alu_addr == 0) cnt = (cnt < 255) ? cnt + 1 : 255;
        else begin a_h = 1; a_ad = alu_addr; a_d = alu_data; a_t = cyc; end
      end
      if (mem_valid && e_mr) begin
        if (mem_addr == 0) cnt = (cnt < 255) ? cnt + 1 : 255;
        else begin m_h = 1; m_ad = mem_addr; m_d = mem_data; m_t = cyc; end
      end
    end
    cyc++;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit mv, input logic [4:0] ma, input logic [31:0] md);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (act !== 49'd0) begin
      failures++; $display("FAIL reset got=%h exp=%h", act, 49'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_in(1, 5'd5, 32'hDEADBEEF, 0, 0, 0); else set_in(0, 0, 0, 0, 0, 0);
      predict(); #2;
      checks++;
      if (act !== exp_v) begin
        failures++; $display("FAIL single cyc=%0d got=%h exp=%h", i, act, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_in(1, 5'd7, 32'h22, 1, 5'd7, 32'h11); else set_in(0, 0, 0, 0, 0, 0);
      predict(); #2;
      checks++;
      if (act !== exp_v) begin
        failures++; $display("FAIL simultaneous cyc=%0d got=%h exp=%h", i, act, exp_v);
      end
      if (i == 1) begin
        checks++;
        if (rf_data_in !== 32'h11 || alu_ready !== 1'b0) begin
          failures++; $display("FAIL simul_mem_first data=%h ready=%b exp data=11 ready=0", rf_data_in, alu_ready);
        end
      end
      tick();
    end
  endtask

  task automatic test_age();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) set_in(1, 5'(10 + i), 32'hA000 + i, 1, 5'(20 + i), 32'hB000 + i);
      else set_in(0, 0, 0, 0, 0, 0);
      predict(); #2;
      checks++;
      if (act !== exp_v) begin
        failures++; $display("FAIL age cyc=%0d got=%h exp=%h", i, act, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_zero();
    int wr_seen = 0, nready = 0;
    for (int i = 0; i < 300; i++) begin
      set_in(1, 5'd0, $urandom, 0, 0, 0);
      predict(); #2;
      if (rf_wr_en) wr_seen++;
      if (!alu_ready) nready++;
      checks++;
      if (act !== exp_v) begin
        failures++; $display("FAIL zero cyc=%0d got=%h exp=%h", i, act, exp_v);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    #2;
    checks++;
    if (zero_drop_cnt !== 8'd255 || wr_seen != 0 || nready != 0) begin
      failures++;
      $display("FAIL zero_sat cnt=%0d writes=%0d not_ready=%0d exp 255/0/0", zero_drop_cnt, wr_seen, nready);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_in(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
      else if (i == 1) set_in(1, 5'd9, 32'h99, 1, 5'd8, 32'h88);
      else set_in(0, 0, 0, 0, 0, 0);
      flush = (i == 1);
      predict(); #2;
      checks++;
      if (act !== exp_v) begin
        failures++; $display("FAIL flush cyc=%0d got=%h exp=%h", i, act, exp_v);
      end
      tick();
      flush = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    set_in(1, 5'd12, 32'hC0C0, 1, 5'd13, 32'hD0D0);
    predict();
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== 49'd0) begin
      failures++; $display("FAIL reset_mid got=%h exp=%h", act, 49'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_in(1, 5'd14, 32'hE0E0, 0, 0, 0); else set_in(0, 0, 0, 0, 0, 0);
      predict(); #2;
      checks++;
      if (act !== exp_v) begin
        failures++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", i, act, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 33; i++) begin
      if (i <= 31) set_in(1, 5'(i), 32'h100 + i, 0, 0, 0); else set_in(0, 0, 0, 0, 0, 0);
      predict(); #2;
      checks++;
      if (act !== exp_v) begin
        failures++; $display("FAIL back_to_back i=%0d got=%h exp=%h", i, act, exp_v);
      end
      if (i >= 2 && i <= 32) begin
        checks++;
        if (rf_wr_en !== 1'b1 || rf_write_addr !== 5'(i - 1)) begin
          failures++; $display("FAIL b2b_order i=%0d wr=%b addr=%0d exp wr=1 addr=%0d", i, rf_wr_en, rf_write_addr, i - 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 31)), $urandom,
             $urandom_range(0, 3) != 0, 5'($urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 31)), $urandom);
      flush = ($urandom_range(0, 19) == 0);
      predict(); #2;
      checks++;
      if (act !== exp_v) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, act, exp_v);
      end
      tick();
      flush = 1'b0;
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_age();
    test_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter COUNT, default 32, register count of the attached register file.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, data width.
REQ-003 SHALL have localparam ADDR_WIDTH, equal to $clog2(COUNT), register address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have ports alu_valid input 1, alu_addr input ADDR_WIDTH and alu_data input BUS_WIDTH: ALU writeback request.
REQ-008 SHALL have port alu_ready  output  1  ALU request accepted at posedge when alu_valid=1.
REQ-009 SHALL have ports mem_valid input 1, mem_addr input ADDR_WIDTH and mem_data input BUS_WIDTH: load writeback request.
REQ-010 SHALL have port mem_ready  output  1  load request accepted at posedge when mem_valid=1.
REQ-011 SHALL have ports rf_wr_en output 1, rf_write_addr output ADDR_WIDTH and rf_data_in output BUS_WIDTH: drive the register file's single write port.
REQ-012 SHALL have port zero_drop_cnt  output  8  saturating count of discarded writes to register 0.
REQ-013 SHALL have port busy  output  1  high when any entry is held.

Function
REQ-014 SHALL hold one entry (addr, data) per requester: alu_held and mem_held.
REQ-015 SHALL accept a request when valid&ready at posedge; a request with addr!=0 is captured into that requester's entry.
REQ-016 SHALL accept a request with addr==0 but never capture it, and SHALL increment zero_drop_cnt by one (two when both requesters do so in one cycle), saturating at 255.
REQ-017 SHALL drive ready = !held | granted for each requester, independent of its own valid.
REQ-018 SHALL drive rf_wr_en=1 whenever a granted entry exists, with rf_write_addr and rf_data_in from that entry; otherwise rf_wr_en=0, with addr and data 0.
REQ-019 SHALL free the granted entry at the posedge ending the grant cycle, so the register file is written one edge after capture (latency 1 when uncontended).
REQ-020 SHALL grant by age: only one held -> that one; both held -> the entry flagged older by register mem_first.
REQ-021 SHALL update mem_first at each posedge where both entries are held afterwards: mem retained and alu newly captured -> 1; alu retained and mem newly captured -> 0; both newly captured the same edge -> 1 (load first).
REQ-022 SHALL, for the same address from both requesters in one cycle, write mem at edge E+1 and alu at E+2, leaving the alu value final.
REQ-023 SHALL produce at most one write per cycle, and SHALL leave no entry held longer than 2 cycles.
REQ-024 SHALL, on flush=1, drive rf_wr_en=0 and ready=0 for that cycle, clear both held flags and mem_first at the posedge, and accept no requests that cycle.
REQ-025 SHALL drive busy = alu_held | mem_held.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear alu_held, mem_held, mem_first and zero_drop_cnt.
REQ-027 SHALL, while rst_n=0, force rf_wr_en=0, rf_write_addr=0, rf_data_in=0, busy=0, and drive alu_ready=mem_ready=0.
REQ-028 SHALL discard any held entry on reset mid-operation, with no register file write, and SHALL accept requests from the first posedge after rst_n rises.

Verification
REQ-029 SHALL be verified for a single ALU write: alu addr=5, data=0xDEADBEEF accepted at edge E -> rf_wr_en=1, addr 5, data 0xDEADBEEF during the cycle after E; busy=0 after E+1.
REQ-030 SHALL be verified for simultaneous requests: mem (addr 7, 0x11) and alu (addr 7, 0x22) at edge E -> writes at E+1 of 0x11 then at E+2 of 0x22; alu_ready=0 in the cycle between.
REQ-031 SHALL be verified for age ordering: mem held and ungranted; alu captured while mem is still held -> mem written first, then alu.
REQ-032 SHALL be verified for $zero: 300 alu writes to addr 0 -> rf_wr_en never asserted, zero_drop_cnt=255, alu_ready=1 throughout.
REQ-033 SHALL be verified for flush and reset: flush with both entries held -> no write, busy=0 next cycle; rst_n low mid-stream -> all outputs 0 immediately, no write after release.
REQ-034 SHALL be verified for back-to-back traffic: continuous alu_valid with addr 1..31 -> one write per cycle, in order, alu_ready held at 1.
